// File: rtl/prog_clock_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_if
// Control and status bundle for the multi-channel programmable clock divider.
// The master side drives the per-channel enables, ratio loads and the global
// phase-align sync. The slave side (the divider) returns the divided clocks,
// the end-of-period ticks and the per-channel run status.
// ---------------------------------------------------------------------------
interface prog_clock_divider_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);

  logic [N_CH-1:0]       en;         // per-channel run enable, level
  logic [N_CH-1:0]       load;       // per-channel ratio load strobe, one cycle
  logic [N_CH*CNT_W-1:0] div_ratio;  // channel i ratio in [i*CNT_W +: CNT_W]
  logic                  sync;       // restart all running channels in phase
  logic [N_CH-1:0]       clk_out;    // divided clocks
  logic [N_CH-1:0]       tick;       // last-cycle-of-period pulses
  logic [N_CH-1:0]       active;     // channel is running

  modport master (
    output en, load, div_ratio, sync,
    input  clk_out, tick, active
  );

  modport slave (
    input  en, load, div_ratio, sync,
    output clk_out, tick, active
  );

endinterface

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
// N_CH independent programmable clock dividers. Each channel keeps a shadow
// ratio (written by load) and an active ratio (used for counting); the active
// ratio is only replaced at a period start, so a ratio change never cuts a
// period short or produces a runt pulse. A global sync restarts every running
// channel at the top of its period so all outputs rise together.
//
// Optional feature: define DIV_DUTY50_EN to stretch the high phase of odd
// ratios by half a clock period using a falling-edge register, giving an
// exact 50% duty cycle. Without the macro the block is purely rising-edge.
// ---------------------------------------------------------------------------
module prog_clock_divider #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input logic                clk,
  input logic                rst,
  prog_clock_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  // Ratios below 2 cannot form a period with both a high and a low phase.
  localparam logic [CNT_W-1:0] DEF_RATIO = (DEF_DIV < 2) ? TWO : CNT_W'(DEF_DIV);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [N_CH-1:0] clk_vec;
  logic [N_CH-1:0] tick_vec;
  logic [N_CH-1:0] act_vec;

  // -------------------------------------------------------------------------
  // Reset release: the channel state is held off for one edge after rst
  // deasserts, so no channel starts on an edge that coincides with release.
  // -------------------------------------------------------------------------
  logic armed_q;

  // Arm the channels one rising edge after reset is released.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of the others; = here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    // Registered channel state
    logic [0:0]       state_q;
    logic [CNT_W-1:0] s_q;      // shadow ratio
    logic [CNT_W-1:0] d_q;      // active ratio
    logic [CNT_W-1:0] cnt_q;    // position within the period, 0 .. d_q-1
    logic             clk_q;
    logic             tick_q;

    // Next-state values
    logic [0:0]       state_d;
    logic [CNT_W-1:0] s_d;
    logic [CNT_W-1:0] d_d;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_d;
    logic             tick_d;

    // Datapath helpers
    logic [CNT_W-1:0] ratio_in;
    logic [CNT_W-1:0] ratio_clamped;
    logic [CNT_W-1:0] s_next;   // shadow including this cycle's load (bypass)
    logic             wrap;     // current cycle is the last of the period
    logic [CNT_W-1:0] nxt;
    logic [CNT_W-1:0] d_run;    // ratio governing the next cycle
    logic [CNT_W-1:0] half;

    assign ratio_in = bus.div_ratio[i*CNT_W +: CNT_W];

    // Ratio clamp, period counter arithmetic and the channel state machine.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
      ratio_clamped = (ratio_in < TWO) ? TWO : ratio_in;
      s_next        = bus.load[i] ? ratio_clamped : s_q;
      wrap          = (cnt_q == d_q - ONE);
      nxt           = wrap ? '0 : cnt_q + ONE;
      d_run         = wrap ? s_next : d_q;
      half          = d_run >> 1;

      state_d = state_q;
      s_d     = s_next;
      d_d     = d_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = tick_q;

      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          tick_d = 1'b0;
          if (bus.en[i]) begin
            // Starting a channel is a period start: take the newest ratio.
            state_d = ST_RUN;
            d_d     = s_next;
            clk_d   = 1'b1;
          end
        end
        ST_RUN: begin
          if (!bus.en[i]) begin
            // Stop immediately, even mid high phase.
            state_d = ST_IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
          end else if (bus.sync) begin
            // Forced period start, same as a wrap but at any phase.
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b0;
            d_d    = s_next;
          end else begin
            cnt_d  = nxt;
            d_d    = d_run;
            clk_d  = (nxt < half);
            tick_d = (nxt == d_run - ONE);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
        end
      endcase
    end

    // Channel registers; updates wait until the reset release has settled.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        s_q     <= DEF_RATIO;
        d_q     <= DEF_RATIO;
        cnt_q   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (armed_q) begin
        state_q <= state_d;
        s_q     <= s_d;
        d_q     <= d_d;
        cnt_q   <= cnt_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

`ifdef DIV_DUTY50_EN
    // Falling-edge copy of the high phase, kept only for odd ratios; ORing it
    // in stretches the high time by half a clock period.
    logic clk_neg_q;

    // Half-cycle extension register, the only falling-edge logic in the block.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) clk_neg_q <= 1'b0;
      else      clk_neg_q <= clk_q & d_q[0];
    end

    // Masking with the run state keeps an enable drop from leaving a stub.
    assign clk_vec[i] = clk_q | (clk_neg_q & (state_q == ST_RUN));
`else
    assign clk_vec[i] = clk_q;
`endif

    assign tick_vec[i] = tick_q;
    assign act_vec[i]  = (state_q == ST_RUN);

    // The counter never leaves the active period and ratios never drop below 2.
    a_cnt_in_period: assert property (@(posedge clk) disable iff (!rst)
      (cnt_q < d_q) && (d_q >= TWO) && (s_q >= TWO));

  end : g_ch

  assign bus.clk_out = clk_vec;
  assign bus.tick    = tick_vec;
  assign bus.active  = act_vec;

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel programmable clock divider: the parametrised successor to the fixed divide-by-2/4/8/16 counter. It supplies N_CH independent divided clock-enable/clock outputs, each with a runtime-loadable ratio, glitch-free ratio change at period boundaries, per-channel enable, a global phase-align sync, and a one-cycle end-of-period tick for downstream timers.

## Interface
- N_CH, 4, number of independent divider channels
- CNT_W, 8, ratio and counter width; max ratio 2^CNT_W-1
- DEF_DIV, 2, reset value of every channel's shadow and active ratio (must be ≥2)
- clk  in  1  system clock; all logic on rising edge except the DUTY50 path
- rst  in  1  asynchronous, active-low reset
- en  in  N_CH  per-channel run enable, level
- load  in  N_CH  per-channel ratio load strobe, one cycle
- div_ratio  in  N_CH*CNT_W  channel i ratio in bits [i*CNT_W +: CNT_W]
- sync  in  1  restart all running channels in phase
- clk_out  out  N_CH  divided clock, registered
- tick  out  N_CH  one-cycle pulse in the last cycle of each period
- active  out  N_CH  channel i is in RUN

## Operation
- Per channel: shadow ratio S, active ratio D, counter cnt[CNT_W-1:0], state IDLE/RUN.
- Ratio clamp: any ratio value 0 or 1 is treated as 2, both on load and at reset.
- load[i]=1: S <= div_ratio slice. D changes only at a period start.
- IDLE: cnt=0, clk_out=0, tick=0. On an edge with en=1: go to RUN, D<=S (or the loaded value if load is also high), cnt<=0, clk_out<=1.
- RUN, per edge: nxt = (cnt==D-1) ? 0 : cnt+1. cnt<=nxt. clk_out <= (nxt < floor(D/2)). tick <= (nxt==D-1).
- Wrap (nxt==0): D<=S. If load is high on the same edge, D takes the new value directly (bypass).
- RUN with en=0: go to IDLE on that edge. cnt, clk_out and tick all go to 0 immediately, so a high phase may be truncated.
- sync=1 (priority over counting; no effect on IDLE channels unless en=1): every channel that is running or starting does cnt<=0, clk_out<=1, tick<=0, D<=S (load bypass applies).
- Counter arithmetic is unsigned CNT_W bits. cnt never exceeds D-1.

## Timing
- Reset (rst=0, async): cnt=0, state IDLE, clk_out=0, tick=0, active=0, S=D=DEF_DIV.
- Latency: clk_out rises on the first edge sampling en=1. active rises on the same edge.
- Period: exactly D clk cycles. clk_out is high for floor(D/2) cycles and low for ceil(D/2) cycles.
- Example, D=4: clk_out is 1,1,0,0 and tick is 0,0,0,1, repeating.
- A ratio loaded at edge e is used from the first wrap at or after e. A period is never cut short by a load.
- Release of rst is synchronised internally. The first edge that acts on en is the second rising edge after deassertion.

## Configuration
- DIV_DUTY50_EN defined: for odd D, clk_out is ORed with a falling-edge copy of the rising-edge high phase. The high time becomes exactly D/2 clk periods.
  - This half-cycle extension is the only negedge logic in the block.
  - Even D, tick and active are unchanged.
  - Under DIV_DUTY50_EN, clk_out is not purely registered on the rising edge.
- DIV_DUTY50_EN undefined: odd D gives floor(D/2) high cycles. No negedge logic exists in the block.

## Test plan
- Reset: hold rst=0 with en=all-ones -> clk_out=0, tick=0, active=0. Release with S=2 -> all channels toggle every cycle and tick pulses every 2nd cycle.
- Ratios 2/3/4/16 on channels 0-3, run 64 cycles -> periods 2/3/4/16. High counts are 1/1/2/8; tick counts are 32/21/16/4.
- Odd duty: D=5, measured in ns at 10 ns clk -> without the macro, high 20 ns / low 30 ns; with DIV_DUTY50_EN, high 25 ns / low 25 ns.
- Mid-period load: D=8, load 3 at cnt=2 -> current period completes at 8 cycles, then 3-cycle periods. A load coinciding with wrap takes effect immediately.
- Enable drop: en=0 while clk_out=1 on D=6 -> next edge clk_out=0, active=0, cnt=0. Re-enable -> clk_out high on the first edge.
- Sync and clamp: channels at D=4 and D=6 at arbitrary phases, pulse sync -> both clk_out rise together and ticks align every 12 cycles. Loading 0 or 1 -> period 2.
